// File: rtl/gpu_pkg.sv
// gpu_pkg: channel FSM state type and index-width helper shared by mem_arbiter_rr
// and rr_picker.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELAY
  } chan_state_t;

  // Width of a consumer index; a single consumer still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_CONSUMERS  = 16;
  localparam int CONSUMER_IDX_BITS  = idx_width(DEFAULT_CONSUMERS);

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational find-first-set over a request mask, starting the
// search at ptr and wrapping around.
module rr_picker #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW:0]    sum;

  // Bit i of rotated is req[(ptr + i) mod N]; scanning downward leaves the
  // lowest set bit, i.e. the first requester at or after ptr.
  always_comb begin
    doubled = {req, req} >> ptr;
    rotated = doubled[N-1:0];
    idx     = '0;
    found   = 1'b0;
    sum     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(i);
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        idx   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter of N consumers onto M memory channels.
// Define MEM_COALESCE_EN to serve identical-address reads with one access.
module mem_arbiter_rr
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 16,
  parameter int NUM_CHANNELS  = 4,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]             mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]             mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]             mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]             mem_write_ready
);

  localparam int   IW = idx_width(NUM_CONSUMERS);
  localparam logic WE = (WRITE_ENABLE != 0);

  chan_state_t                                 state      [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0]  grp_q;
  logic [NUM_CHANNELS-1:0]                     is_write_q;
  logic [NUM_CHANNELS-1:0]                     rd_valid_q;
  logic [NUM_CHANNELS-1:0]                     wr_valid_q;
  logic [ADDR_BITS-1:0]                        rd_addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]                        wr_addr_q  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]                        wr_data_q  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]                    rd_ready_q;
  logic [NUM_CONSUMERS-1:0]                    wr_ready_q;
  logic [DATA_BITS-1:0]                        rd_data_q  [NUM_CONSUMERS];
  logic [IW-1:0]                               rr_ptr;

  logic [ADDR_BITS-1:0] rd_addr_in   [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0] wr_addr_in   [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] wr_data_in   [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] mem_rdata_in [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0]                    req_mask;
  logic [NUM_CONSUMERS-1:0]                    claimed;
  logic [NUM_CHANNELS-1:0]                     grant;
  logic [NUM_CHANNELS-1:0]                     grant_read;
  logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0]  grant_grp;
  logic [ADDR_BITS-1:0]                        pick_raddr [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]                        pick_waddr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]                        pick_wdata [NUM_CHANNELS];
  logic                                        grant_any;
  logic [IW-1:0]                               last_hi;
  logic [IW-1:0]                               next_ptr;

  for (genvar k = 0; k < NUM_CONSUMERS; k++) begin : g_cons
    assign rd_addr_in[k] = consumer_read_address[k*ADDR_BITS +: ADDR_BITS];
    assign wr_addr_in[k] = consumer_write_address[k*ADDR_BITS +: ADDR_BITS];
    assign wr_data_in[k] = consumer_write_data[k*DATA_BITS +: DATA_BITS];
    assign consumer_read_data[k*DATA_BITS +: DATA_BITS] = rd_data_q[k];
  end

  assign req_mask = consumer_read_valid | (WE ? consumer_write_valid : '0);

  always_comb begin
    claimed = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state[c] != IDLE) claimed = claimed | grp_q[c];
    end
  end

  // Each channel sees only what lower-indexed channels left unclaimed this cycle.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic [NUM_CONSUMERS-1:0] avail_in;
    logic [NUM_CONSUMERS-1:0] avail_out;
    logic [NUM_CONSUMERS-1:0] grp;
    logic [IW-1:0]            idx;
    logic                     found;

    if (c == 0) begin : g_head
      assign avail_in = req_mask & ~claimed;
    end else begin : g_tail
      assign avail_in = g_chan[c-1].avail_out;
    end

    rr_picker #(.N(NUM_CONSUMERS), .IW(IW)) u_picker (
      .req   (avail_in),
      .ptr   (rr_ptr),
      .idx   (idx),
      .found (found)
    );

    always_comb begin
      grp = '0;
      if (found) begin
        grp[idx] = 1'b1;
`ifdef MEM_COALESCE_EN
        if (consumer_read_valid[idx]) begin
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            if (avail_in[k] && consumer_read_valid[k] && (rd_addr_in[k] == rd_addr_in[idx]))
              grp[k] = 1'b1;
          end
        end
`endif
      end
    end

    assign grant[c]      = found && (state[c] == IDLE);
    assign grant_read[c] = consumer_read_valid[idx];
    assign grant_grp[c]  = grant[c] ? grp : '0;
    assign avail_out     = avail_in & ~grant_grp[c];
    assign pick_raddr[c] = rd_addr_in[idx];
    assign pick_waddr[c] = wr_addr_in[idx];
    assign pick_wdata[c] = wr_data_in[idx];
    assign mem_rdata_in[c] = mem_read_data[c*DATA_BITS +: DATA_BITS];

    assign mem_read_address[c*ADDR_BITS +: ADDR_BITS]  = rd_addr_q[c];
    assign mem_write_address[c*ADDR_BITS +: ADDR_BITS] = WE ? wr_addr_q[c] : '0;
    assign mem_write_data[c*DATA_BITS +: DATA_BITS]    = WE ? wr_data_q[c] : '0;
  end

  assign mem_read_valid       = rd_valid_q;
  assign mem_write_valid      = WE ? wr_valid_q : '0;
  assign consumer_read_ready  = rd_ready_q;
  assign consumer_write_ready = WE ? wr_ready_q : '0;

  // The last granting channel holds the furthest consumer in rotation order.
  always_comb begin
    grant_any = 1'b0;
    last_hi   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant[c]) begin
        grant_any = 1'b1;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          if (grant_grp[c][k]) last_hi = IW'(k);
        end
      end
    end
    next_ptr = (last_hi == IW'(NUM_CONSUMERS - 1)) ? '0 : last_hi + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_valid_q <= '0;
      wr_valid_q <= '0;
      is_write_q <= '0;
      grp_q      <= '0;
      for (int k = 0; k < NUM_CONSUMERS; k++) rd_data_q[k] <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state[c]     <= IDLE;
        rd_addr_q[c] <= '0;
        wr_addr_q[c] <= '0;
        wr_data_q[c] <= '0;
      end
    end else begin
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      if (grant_any) rr_ptr <= next_ptr;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state[c])
          IDLE: begin
            if (grant[c]) begin
              grp_q[c] <= grant_grp[c];
              if (grant_read[c]) begin
                state[c]      <= READ_WAIT;
                is_write_q[c] <= 1'b0;
                rd_valid_q[c] <= 1'b1;
                rd_addr_q[c]  <= pick_raddr[c];
              end else begin
                state[c]      <= WRITE_WAIT;
                is_write_q[c] <= 1'b1;
                wr_valid_q[c] <= 1'b1;
                wr_addr_q[c]  <= pick_waddr[c];
                wr_data_q[c]  <= pick_wdata[c];
              end
            end
          end
          READ_WAIT: begin
            if (mem_read_ready[c]) begin
              rd_valid_q[c] <= 1'b0;
              state[c]      <= RELAY;
              for (int k = 0; k < NUM_CONSUMERS; k++) begin
                if (grp_q[c][k]) begin
                  rd_ready_q[k] <= 1'b1;
                  rd_data_q[k]  <= mem_rdata_in[c];
                end
              end
            end
          end
          WRITE_WAIT: begin
            if (mem_write_ready[c]) begin
              wr_valid_q[c] <= 1'b0;
              state[c]      <= RELAY;
              for (int k = 0; k < NUM_CONSUMERS; k++) begin
                if (grp_q[c][k]) wr_ready_q[k] <= 1'b1;
              end
            end
          end
          RELAY: begin
            // Hold the claim until every owner has dropped the request it was served for.
            if ((grp_q[c] & (is_write_q[c] ? consumer_write_valid : consumer_read_valid)) == '0)
              state[c] <= IDLE;
          end
          default: state[c] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed self-checking bench; a 16x4 arbiter plus a 4x1
// write-disabled arbiter, each behind a memory that returns address + 0x99.
module tb_mem_arbiter_rr;

  localparam int N  = 16;
  localparam int M  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0]    rd_valid, rd_ready, wr_valid, wr_ready;
  logic [N*AW-1:0] rd_addr, wr_addr;
  logic [N*DW-1:0] rd_data, wr_data;
  logic [M-1:0]    m_rv, m_rr, m_wv, m_wr;
  logic [M*AW-1:0] m_ra, m_wa;
  logic [M*DW-1:0] m_rd, m_wd;
  logic            mem_stall;

  assign m_rr = m_rv & ~{M{mem_stall}};
  assign m_wr = m_wv & ~{M{mem_stall}};
  for (genvar c = 0; c < M; c++) begin : g_mem
    assign m_rd[c*DW +: DW] = m_ra[c*AW +: AW] + 8'h99;
  end

  logic [3:0]  s_rv, s_rr, s_wv, s_wr;
  logic [31:0] s_ra, s_wa, s_rd, s_wd;
  logic [0:0]  s_mrv, s_mrr, s_mwv, s_mwr;
  logic [7:0]  s_mra, s_mrd, s_mwa, s_mwd;

  assign s_mrr = s_mrv;
  assign s_mwr = s_mwv;
  assign s_mrd = s_mra + 8'h99;

  mem_arbiter_rr #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N), .NUM_CHANNELS(M), .WRITE_ENABLE(1)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rd_valid), .consumer_read_address(rd_addr),
    .consumer_read_ready(rd_ready), .consumer_read_data(rd_data),
    .consumer_write_valid(wr_valid), .consumer_write_address(wr_addr),
    .consumer_write_data(wr_data), .consumer_write_ready(wr_ready),
    .mem_read_valid(m_rv), .mem_read_address(m_ra),
    .mem_read_ready(m_rr), .mem_read_data(m_rd),
    .mem_write_valid(m_wv), .mem_write_address(m_wa),
    .mem_write_data(m_wd), .mem_write_ready(m_wr)
  );

  mem_arbiter_rr #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(0)
  ) dut_small (
    .clk(clk), .reset(reset),
    .consumer_read_valid(s_rv), .consumer_read_address(s_ra),
    .consumer_read_ready(s_rr), .consumer_read_data(s_rd),
    .consumer_write_valid(s_wv), .consumer_write_address(s_wa),
    .consumer_write_data(s_wd), .consumer_write_ready(s_wr),
    .mem_read_valid(s_mrv), .mem_read_address(s_mra),
    .mem_read_ready(s_mrr), .mem_read_data(s_mrd),
    .mem_write_valid(s_mwv), .mem_write_address(s_mwa),
    .mem_write_data(s_mwd), .mem_write_ready(s_mwr)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_valid = '0; rd_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0;
    s_rv = '0; s_ra = '0; s_wv = '0; s_wa = '0; s_wd = '0;
    mem_stall = 1'b0;
    repeat (3) tick();
    checks++; if (m_rv !== 4'h0) begin failures++; $display("[TB] FAIL reset_mem_read_valid actual=%h expected=0", m_rv); end
    checks++; if (m_wv !== 4'h0) begin failures++; $display("[TB] FAIL reset_mem_write_valid actual=%h expected=0", m_wv); end
    checks++; if (m_ra !== '0) begin failures++; $display("[TB] FAIL reset_mem_read_address actual=%h expected=0", m_ra); end
    checks++; if (rd_ready !== '0) begin failures++; $display("[TB] FAIL reset_read_ready actual=%h expected=0", rd_ready); end
    checks++; if (wr_ready !== '0) begin failures++; $display("[TB] FAIL reset_write_ready actual=%h expected=0", wr_ready); end
    checks++; if (rd_data !== '0) begin failures++; $display("[TB] FAIL reset_read_data actual=%h expected=0", rd_data); end
    checks++; if (dut.rr_ptr !== 4'd0) begin failures++; $display("[TB] FAIL reset_rr_ptr actual=%0d expected=0", dut.rr_ptr); end
    checks++; if (s_mrv !== 1'b0) begin failures++; $display("[TB] FAIL reset_small_mem_read_valid actual=%h expected=0", s_mrv); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    rd_addr[0 +: 8] = 8'h12;
    rd_valid[0] = 1'b1;
    tick();
    checks++; if (m_rv !== 4'b0001) begin failures++; $display("[TB] FAIL single_mem_read_valid actual=%b expected=0001", m_rv); end
    checks++; if (m_ra[7:0] !== 8'h12) begin failures++; $display("[TB] FAIL single_mem_read_address actual=%h expected=12", m_ra[7:0]); end
    checks++; if (rd_ready !== '0) begin failures++; $display("[TB] FAIL single_early_ready actual=%h expected=0", rd_ready); end
    tick();
    checks++; if (rd_ready !== 16'h0001) begin failures++; $display("[TB] FAIL single_ready_pulse actual=%h expected=0001", rd_ready); end
    checks++; if (rd_data[7:0] !== 8'hAB) begin failures++; $display("[TB] FAIL single_read_data actual=%h expected=ab", rd_data[7:0]); end
    rd_valid[0] = 1'b0;
    tick();
    checks++; if (rd_ready !== '0) begin failures++; $display("[TB] FAIL single_pulse_width actual=%h expected=0", rd_ready); end
    checks++; if (rd_data[7:0] !== 8'hAB) begin failures++; $display("[TB] FAIL single_data_held actual=%h expected=ab", rd_data[7:0]); end
    repeat (2) tick();
  endtask

  task automatic test_write();
    int pulses = 0;
    int stray  = 0;
    mem_stall = 1'b1;
    wr_addr[3*AW +: AW] = 8'h20;
    wr_data[3*DW +: DW] = 8'h7F;
    wr_valid[3] = 1'b1;
    tick();
    checks++; if (m_wv !== 4'b0001) begin failures++; $display("[TB] FAIL write_mem_write_valid actual=%b expected=0001", m_wv); end
    checks++; if (m_wa[7:0] !== 8'h20) begin failures++; $display("[TB] FAIL write_mem_address actual=%h expected=20", m_wa[7:0]); end
    checks++; if (m_wd[7:0] !== 8'h7F) begin failures++; $display("[TB] FAIL write_mem_data actual=%h expected=7f", m_wd[7:0]); end
    checks++; if (m_rv !== 4'b0000) begin failures++; $display("[TB] FAIL write_no_read actual=%b expected=0000", m_rv); end
    mem_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr_ready[3]) begin pulses++; wr_valid[3] = 1'b0; end
      if ((wr_ready & 16'hFFF7) != '0) stray++;
    end
    checks++; if (pulses !== 1) begin failures++; $display("[TB] FAIL write_ready_pulses actual=%0d expected=1", pulses); end
    checks++; if (stray !== 0) begin failures++; $display("[TB] FAIL write_stray_ready actual=%0d expected=0", stray); end
    checks++; if (wr_valid[3] !== 1'b0) begin failures++; $display("[TB] FAIL write_completed actual=%b expected=0", wr_valid[3]); end
  endtask

  task automatic test_coalesce();
    int ids [3] = '{0, 5, 9};
    logic [3:0] exp_ch;
`ifdef MEM_COALESCE_EN
    exp_ch = 4'b0001;
`else
    exp_ch = 4'b0111;
`endif
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) rd_addr[ids[i]*AW +: AW] = 8'h40;
    rd_valid = 16'h0221;
    tick();
    checks++; if (m_rv !== exp_ch) begin failures++; $display("[TB] FAIL coalesce_channels actual=%b expected=%b", m_rv, exp_ch); end
    checks++; if (m_ra[7:0] !== 8'h40) begin failures++; $display("[TB] FAIL coalesce_address actual=%h expected=40", m_ra[7:0]); end
    mem_stall = 1'b0;
    tick();
    checks++; if (rd_ready !== 16'h0221) begin failures++; $display("[TB] FAIL coalesce_ready actual=%h expected=0221", rd_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_data[ids[i]*DW +: DW] !== 8'hD9) begin
        failures++;
        $display("[TB] FAIL coalesce_data_%0d actual=%h expected=d9", ids[i], rd_data[ids[i]*DW +: DW]);
      end
    end
    rd_valid = '0;
    tick();
    checks++; if (rd_ready !== '0) begin failures++; $display("[TB] FAIL coalesce_pulse_width actual=%h expected=0", rd_ready); end
    repeat (2) tick();
  endtask

  task automatic test_rr_order();
    int exp_order [4] = '{2, 3, 0, 1};
    logic [7:0] exp_data [4] = '{8'hAB, 8'hAC, 8'hA9, 8'hAA};
    int got_order [4] = '{-1, -1, -1, -1};
    logic [7:0] got_data [4];
    int n = 0;
    s_ra = 32'h13121110;
    s_rv = 4'b0010;
    repeat (2) tick();
    checks++; if (s_rr !== 4'b0010) begin failures++; $display("[TB] FAIL rr_prime_ready actual=%b expected=0010", s_rr); end
    checks++; if (s_rd[15:8] !== 8'hAA) begin failures++; $display("[TB] FAIL rr_prime_data actual=%h expected=aa", s_rd[15:8]); end
    s_rv = '0;
    repeat (2) tick();
    s_rv = 4'b1111;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (s_rr[i] && n < 4) begin
          got_order[n] = i;
          got_data[n]  = s_rd[i*8 +: 8];
          n++;
          s_rv[i] = 1'b0;
        end
      end
    end
    checks++; if (n !== 4) begin failures++; $display("[TB] FAIL rr_served_count actual=%0d expected=4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_order[i] !== exp_order[i]) begin
        failures++;
        $display("[TB] FAIL rr_order_%0d actual=%0d expected=%0d", i, got_order[i], exp_order[i]);
      end
      checks++;
      if (got_data[i] !== exp_data[i]) begin
        failures++;
        $display("[TB] FAIL rr_data_%0d actual=%h expected=%h", i, got_data[i], exp_data[i]);
      end
    end
    s_rv = '0;
    repeat (2) tick();
  endtask

  task automatic test_write_disabled();
    s_wa[3*8 +: 8] = 8'h20;
    s_wd[3*8 +: 8] = 8'h7F;
    s_wv[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (s_mwv !== 1'b0) begin failures++; $display("[TB] FAIL wdis_mem_write_valid actual=%b expected=0", s_mwv); end
      checks++; if (s_wr !== 4'b0000) begin failures++; $display("[TB] FAIL wdis_write_ready actual=%b expected=0000", s_wr); end
    end
    checks++; if (s_mwa !== 8'h00 || s_mwd !== 8'h00) begin failures++; $display("[TB] FAIL wdis_mem_write_bus actual=%h/%h expected=00/00", s_mwa, s_mwd); end
    s_wv = '0;
    tick();
  endtask

  task automatic test_fairness();
    int served [N];
    int start  [N];
    int max_wait = 0;
    for (int i = 0; i < N; i++) begin
      served[i] = 0;
      start[i]  = 0;
      rd_addr[i*AW +: AW] = 8'(i);
    end
    rd_valid = '0;
    for (int cyc = 0; cyc < 240; cyc++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (rd_ready[i]) begin
          served[i]++;
          if (cyc - start[i] > max_wait) max_wait = cyc - start[i];
          checks++;
          if (rd_data[i*DW +: DW] !== 8'(i + 'h99)) begin
            failures++;
            $display("[TB] FAIL fair_data_%0d actual=%h expected=%h", i, rd_data[i*DW +: DW], 8'(i + 'h99));
          end
          rd_valid[i] = 1'b0;
        end else if (!rd_valid[i] && cyc < 200) begin
          rd_valid[i] = 1'b1;
          start[i] = cyc;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (served[i] < 8) begin
        failures++;
        $display("[TB] FAIL fair_served_%0d actual=%0d expected>=8", i, served[i]);
      end
    end
    checks++; if (max_wait > 18) begin failures++; $display("[TB] FAIL fair_max_wait actual=%0d expected<=18", max_wait); end
    checks++; if (rd_valid !== '0) begin failures++; $display("[TB] FAIL fair_drain actual=%h expected=0", rd_valid); end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    rd_addr[2*AW +: AW] = 8'h33;
    rd_valid[2] = 1'b1;
    tick();
    checks++; if ((m_rv != '0) !== 1'b1) begin failures++; $display("[TB] FAIL mid_in_flight actual=%b expected=nonzero", m_rv); end
    reset = 1'b1;
    tick();
    checks++; if (m_rv !== 4'h0) begin failures++; $display("[TB] FAIL mid_mem_read_valid actual=%b expected=0", m_rv); end
    checks++; if (m_ra !== '0) begin failures++; $display("[TB] FAIL mid_mem_read_address actual=%h expected=0", m_ra); end
    checks++; if (rd_ready !== '0) begin failures++; $display("[TB] FAIL mid_read_ready actual=%h expected=0", rd_ready); end
    checks++; if (rd_data !== '0) begin failures++; $display("[TB] FAIL mid_read_data actual=%h expected=0", rd_data); end
    checks++; if (dut.rr_ptr !== 4'd0) begin failures++; $display("[TB] FAIL mid_rr_ptr actual=%0d expected=0", dut.rr_ptr); end
    tick();
    checks++; if (rd_ready !== '0) begin failures++; $display("[TB] FAIL mid_late_ready actual=%h expected=0", rd_ready); end
    rd_valid = '0;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_coalesce();
    test_rr_order();
    test_write_disabled();
    test_fairness();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
